// File: rtl/cla_nibble_sequencer.sv
// Nibble-serial add/subtract engine built around one 4-bit carry-lookahead
// adder. Wide operands are processed one nibble per clock, least significant
// nibble first, with the inter-nibble carry held in a register.

// 4-bit carry-lookahead adder; c[i] is the carry out of bit i.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic [3:0] c
);

  logic [3:0] g;
  logic [3:0] p;

  // Generate/propagate terms and fully expanded lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ {c[2:0], cin};
  end

endmodule

// state | meaning
// IDLE  | waiting for a request, start_ready high
// RUN   | one nibble per clock through the shared cla, idx = nibble in flight
// DONE  | result and flags held, done_valid high until done_ready
module cla_nibble_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 op_cin,
  input  logic                 sub,
  output logic                 busy,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout,
  output logic                 overflow,
  output logic                 done_valid,
  input  logic                 done_ready
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          carry_r;
  logic [IW-1:0] idx;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_s;
  logic [3:0]    nib_c;

  // Select the nibble currently in flight from the latched operands.
  always_comb begin
    nib_a = a_r[4*idx +: 4];
    nib_b = b_r[4*idx +: 4];
  end

  cla4 u_cla (
    .a   (nib_a),
    .b   (nib_b),
    .cin (carry_r),
    .s   (nib_s),
    .c   (nib_c)
  );

  // Handshake status depends on state only, never on an input.
  always_comb begin
    start_ready = (state == IDLE);
    busy        = (state != IDLE);
  end

  // Sequencer: latch operands on accept, ripple nibbles, hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      a_r        <= '0;
      b_r        <= '0;
      carry_r    <= 1'b0;
      idx        <= '0;
      result     <= '0;
      cout       <= 1'b0;
      overflow   <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_r     <= op_a;
            // Subtraction is A + ~B + 1, so B is inverted once here.
            b_r     <= sub ? ~op_b : op_b;
            carry_r <= sub ? 1'b1 : op_cin;
            idx     <= '0;
            result  <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          result[4*idx +: 4] <= nib_s;
          carry_r            <= nib_c[3];
          if (idx == LAST_IDX) begin
            cout       <= nib_c[3];
            overflow   <= nib_c[2] ^ nib_c[3];
            done_valid <= 1'b1;
            state      <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer (NIBBLES=4) with an expected-result
// queue filled at request time and drained when done_valid appears.
module tb_cla_nibble_sequencer;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         sub;
  logic         busy;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic         done_valid;
  logic         done_ready;

  exp_t q[$];
  exp_t last_exp;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;

  cla_nibble_sequencer #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .sub         (sub),
    .busy        (busy),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .done_valid  (done_valid),
    .done_ready  (done_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic s);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   sum;
    bb   = s ? ~b : b;
    sum  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : cin)};
    e.res = sum[W-1:0];
    e.co  = sum[W];
    e.ov  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic cin, input logic s, input bit push);
    int n;
    @(negedge clk);
    op_a = a; op_b = b; op_cin = cin; sub = s; start_valid = 1'b1;
    if (push) q.push_back(model(a, b, cin, s));
    n = 0;
    while (!start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", {31'd0, n < 20}, 32'd1);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    start_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit scramble, input bit hold);
    int   n;
    exp_t e;
    n = 0;
    while (!done_valid && n < 20) begin
      if (scramble) begin
        op_a = W'($urandom); op_b = W'($urandom);
        op_cin = ~op_cin; sub = ~sub;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_done_wait"}, {31'd0, n < 20}, 32'd1);
    check({tag, "_latency"}, 32'(cyc - acc_cyc), N);
    if (q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'(q.size()), 1);
      e = '0;
    end else begin
      e = q.pop_front();
    end
    last_exp = e;
    check({tag, "_result"}, {16'd0, result}, {16'd0, e.res});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.co});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, e.ov});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    check({tag, "_sready_done"}, {31'd0, start_ready}, 32'd0);
    if (!hold) begin
      done_ready = 1'b1;
      @(negedge clk);
      done_ready = 1'b0;
      check({tag, "_dv_drop"}, {31'd0, done_valid}, 32'd0);
      check({tag, "_idle"}, {30'd0, start_ready, busy}, 32'd2);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rs, rc;
    int           dv_seen;

    rst = 1'b1; start_valid = 1'b0; done_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {result, cout, overflow, done_valid, busy, start_ready},
          {16'd0, 5'b00001});
    rst = 1'b0;

    // 1..3: carry chain, wrap, signed overflow, subtraction with ignored cin
    drive_start(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1); wait_done("add_ff", 0, 0);
    drive_start(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1); wait_done("add_wrap", 0, 0);
    drive_start(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1); wait_done("add_ovf", 0, 0);
    drive_start(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1); wait_done("sub_neg", 0, 0);
    drive_start(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1); wait_done("sub_pos", 0, 0);
    drive_start(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1); wait_done("sub_ovf", 0, 0);
    drive_start(16'h1234, 16'h0FFF, 1'b1, 1'b0, 1'b1); wait_done("add_cin", 0, 0);

    // 4: consumer stalls; pending request held off until IDLE
    drive_start(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b1); wait_done("stall", 0, 1);
    op_a = 16'h0102; op_b = 16'h0304; op_cin = 1'b0; sub = 1'b0; start_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_result", {16'd0, result}, {16'd0, last_exp.res});
      check("stall_flags", {29'd0, cout, overflow, done_valid}, {29'd0, last_exp.co, last_exp.ov, 1'b1});
      check("stall_sready", {31'd0, start_ready}, 32'd0);
    end
    q.push_back(model(16'h0102, 16'h0304, 1'b0, 1'b0));
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
    check("stall_release", {30'd0, start_ready, done_valid}, 32'd2);
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    start_valid = 1'b0;
    wait_done("stall_next", 0, 0);

    // 5: reset during the second RUN cycle aborts the operation
    drive_start(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_partial", {16'd0, result}, 32'h0003);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {result, cout, overflow, done_valid, busy, start_ready},
          {16'd0, 5'b00001});
    dv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done_valid) dv_seen++;
    end
    check("abort_no_done", 32'(dv_seen), 32'd0);
    drive_start(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1); wait_done("post_rst", 0, 0);

    // 6: operand inputs churn while the operation runs
    drive_start(16'h9ABC, 16'h6543, 1'b1, 1'b0, 1'b1); wait_done("churn_add", 1, 0);
    drive_start(16'h3000, 16'h4001, 1'b0, 1'b1, 1'b1); wait_done("churn_sub", 1, 0);

    // a few random operations
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      rc = 1'($urandom); rs = 1'($urandom);
      drive_start(ra, rb, rc, rs, 1'b1);
      wait_done("rand", 0, 0);
    end

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
